// File: rtl/xbar_pipelined.sv
// Pipelined N x N flit crossbar: per-output grant resolution, then a registered main + skid stage per output.
// Optional per-output handshake counters (flit_cnt_o) are built when XBAR_FLIT_CNT_EN is defined.

module xbar_out_lane #(
  parameter int FLIT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              xfer_i,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic              ready_i,
  output logic [FLIT_W-1:0] data_o,
  output logic              valid_o,
  output logic              can_acc_o
`ifdef XBAR_FLIT_CNT_EN
  ,
  output logic [15:0]       cnt_o
`endif
);
  logic [FLIT_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic              main_free;

  // The skid absorbs the one flit that can arrive while main is stalled,
  // so upstream ready never looks at downstream ready.
  assign can_acc_o = !skid_v_q;
  assign main_free = !main_v_q || ready_i;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (main_free) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = xfer_i;
        if (xfer_i) skid_d = flit_i;
      end else begin
        main_v_d = xfer_i;
        if (xfer_i) main_d = flit_i;
      end
    end else if (xfer_i) begin
      skid_d   = flit_i;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign data_o  = main_q;
  assign valid_o = main_v_q;

`ifdef XBAR_FLIT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (main_v_q && ready_i && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif
endmodule

module xbar_pipelined #(
  parameter int PORT_NUM = 5,
  parameter int FLIT_W   = 32,
  parameter int SEL_W    = $clog2(PORT_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORT_NUM*FLIT_W-1:0] data_i,
  input  logic [PORT_NUM-1:0]        valid_i,
  output logic [PORT_NUM-1:0]        ready_o,
  input  logic [PORT_NUM*SEL_W-1:0]  sel_i,
  input  logic [PORT_NUM-1:0]        sel_valid_i,
  output logic [PORT_NUM*FLIT_W-1:0] data_o,
  output logic [PORT_NUM-1:0]        valid_o,
  input  logic [PORT_NUM-1:0]        ready_i,
  output logic                       conflict_o,
  output logic                       sel_err_o
`ifdef XBAR_FLIT_CNT_EN
  ,
  output logic [PORT_NUM*16-1:0]     flit_cnt_o
`endif
);
  localparam logic [SEL_W:0] PN = PORT_NUM[SEL_W:0];

  logic [PORT_NUM-1:0][FLIT_W-1:0] din, in_d;
  logic [PORT_NUM-1:0][SEL_W-1:0]  sel;
  logic [PORT_NUM-1:0]             eff, win, in_v, xfer, can_acc, bad;
  logic [PORT_NUM-1:0]             rdy;
  logic                            conflict_q, conflict_d, sel_err_q, sel_err_d;

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      din[i] = data_i[i*FLIT_W +: FLIT_W];
      sel[i] = sel_i[i*SEL_W +: SEL_W];
    end
  end

  // Lowest-indexed output keeps a contested input; higher ones are masked.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      bad[o] = sel_valid_i[o] && !({1'b0, sel[o]} < PN);
      eff[o] = sel_valid_i[o] && ({1'b0, sel[o]} < PN);
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      win[o] = eff[o];
      for (int p = 0; p < o; p++)
        if (eff[p] && sel[p] == sel[o]) win[o] = 1'b0;
    end
  end

  always_comb begin
    rdy = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      in_d[o] = '0;
      in_v[o] = 1'b0;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (sel[o] == SEL_W'(i)) begin
          in_d[o] = din[i];
          in_v[o] = valid_i[i];
          if (win[o] && can_acc[o]) rdy[i] = 1'b1;
        end
      end
      xfer[o] = win[o] && in_v[o] && can_acc[o];
    end
  end

  assign ready_o    = rdy;
  assign conflict_d = |(eff & ~win);
  assign sel_err_d  = |bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign conflict_o = conflict_q;
  assign sel_err_o  = sel_err_q;

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_lane
    xbar_out_lane #(.FLIT_W(FLIT_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .xfer_i   (xfer[o]),
      .flit_i   (in_d[o]),
      .ready_i  (ready_i[o]),
      .data_o   (data_o[o*FLIT_W +: FLIT_W]),
      .valid_o  (valid_o[o]),
      .can_acc_o(can_acc[o])
`ifdef XBAR_FLIT_CNT_EN
      ,
      .cnt_o    (flit_cnt_o[o*16 +: 16])
`endif
    );
  end
endmodule

// File: tb/tb_xbar_pipelined.sv
// Directed bench for xbar_pipelined: single flit, backpressure, conflict, bad select, mid-flight reset.
module tb_xbar_pipelined;
  localparam int P = 5, W = 32, S = 3;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic [P*W-1:0] data_i = '0, data_o;
  logic [P-1:0]   valid_i = '0, ready_o, sel_valid_i = '0, valid_o, ready_i = '0;
  logic [P*S-1:0] sel_i = '0;
  logic           conflict_o, sel_err_o;
`ifdef XBAR_FLIT_CNT_EN
  logic [P*16-1:0] flit_cnt_o;
`endif

  int n_chk = 0, n_fail = 0;

  xbar_pipelined #(.PORT_NUM(P), .FLIT_W(W), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .sel_i(sel_i), .sel_valid_i(sel_valid_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .conflict_o(conflict_o), .sel_err_o(sel_err_o)
`ifdef XBAR_FLIT_CNT_EN
    , .flit_cnt_o(flit_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_i = '0; valid_i = '0; sel_i = '0; sel_valid_i = '0; ready_i = '1;
  endtask

  task automatic grant(input int o, input logic [S-1:0] v);
    sel_i[o*S +: S] = v;
    sel_valid_i[o]  = 1'b1;
  endtask

  task automatic offer(input int i, input logic [W-1:0] d);
    data_i[i*W +: W] = d;
    valid_i[i]       = 1'b1;
  endtask

  // backpressure table, cycles c0..c7
  logic       bp_rdyi [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
  logic       bp_rdyo [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  logic       bp_vo   [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
  logic [W-1:0] bp_do [8] = '{0, 1, 1, 1, 2, 3, 4, 0};

  initial begin
    idle();
    ready_i = '0;
    repeat (3) tick();
    chk("rst_valid_o", 64'(valid_o), 64'h0);
    chk("rst_data_o_lo", data_o[63:0], 64'h0);
    chk("rst_conflict", 64'(conflict_o), 64'h0);
    chk("rst_sel_err", 64'(sel_err_o), 64'h0);
    rst_n = 1'b1;
    idle();

    // single flit: input 3 -> output 2
    tick();
    grant(2, 3'd3); offer(3, 32'hA5A5_0001);
    #1 chk("single_ready_o", 64'(ready_o), 64'h08);
    tick(); idle();
    chk("single_valid_o", 64'(valid_o), 64'h04);
    chk("single_data_o2", 64'(data_o[2*W +: W]), 64'hA5A5_0001);
    tick();
    chk("single_drained", 64'(valid_o), 64'h00);

    // backpressure: input 1 -> output 0, flits 1..4
    begin
      int nxt = 1;
      for (int c = 0; c < 8; c++) begin
        tick(); idle();
        ready_i[0] = bp_rdyi[c];
        if (c < 6) grant(0, 3'd1);
        if (nxt <= 4) offer(1, W'(nxt));
        #1;
        chk($sformatf("bp_ready_o1_c%0d", c), 64'(ready_o[1]), 64'(bp_rdyo[c]));
        chk($sformatf("bp_valid_o0_c%0d", c), 64'(valid_o[0]), 64'(bp_vo[c]));
        if (bp_vo[c]) chk($sformatf("bp_data_o0_c%0d", c), 64'(data_o[W-1:0]), 64'(bp_do[c]));
        if (ready_o[1] && valid_i[1]) nxt++;
      end
      chk("bp_all_sent", 64'(nxt), 64'd5);
    end

    // conflict: outputs 1 and 4 both pick input 0
    tick(); idle();
    grant(1, 3'd0); grant(4, 3'd0); offer(0, 32'hC0FF_EE00);
    #1 chk("cf_ready_o", 64'(ready_o), 64'h01);
    chk("cf_conflict_before", 64'(conflict_o), 64'h0);
    tick(); idle();
    chk("cf_valid_o", 64'(valid_o), 64'h02);
    chk("cf_data_o1", 64'(data_o[1*W +: W]), 64'hC0FF_EE00);
    chk("cf_conflict", 64'(conflict_o), 64'h1);
    tick();
    chk("cf_conflict_pulse", 64'(conflict_o), 64'h0);

    // bad select on output 0
    tick(); idle();
    grant(0, 3'd7); valid_i = '1;
    #1 chk("se_ready_o", 64'(ready_o), 64'h00);
    tick(); idle();
    chk("se_valid_o", 64'(valid_o), 64'h00);
    chk("se_sel_err", 64'(sel_err_o), 64'h1);
    chk("se_no_conflict", 64'(conflict_o), 64'h0);
    tick();
    chk("se_sel_err_pulse", 64'(sel_err_o), 64'h0);

    // fill output 2 (main + skid) from input 4, then reset mid-flight
    tick(); idle();
    ready_i[2] = 1'b0; grant(2, 3'd4); offer(4, 32'h11);
    tick();
    ready_i[2] = 1'b0; grant(2, 3'd4); offer(4, 32'h22);
    tick();
    ready_i[2] = 1'b0; grant(2, 3'd4); offer(4, 32'h33);
    #1 chk("full_ready_o", 64'(ready_o), 64'h00);
    chk("full_data_o2", 64'(data_o[2*W +: W]), 64'h11);
    rst_n = 1'b0;
    #1 chk("rst_async_valid_o", 64'(valid_o), 64'h00);
    #1 rst_n = 1'b1;
    tick(); idle();
    grant(2, 3'd4); offer(4, 32'h33);
    #1 chk("post_rst_ready_o", 64'(ready_o), 64'h10);
    tick(); idle();
    chk("post_rst_valid_o", 64'(valid_o), 64'h04);
    chk("post_rst_data_o2", 64'(data_o[2*W +: W]), 64'h33);

`ifdef XBAR_FLIT_CNT_EN
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; idle();
    chk("cnt_reset", 64'(flit_cnt_o), 64'h0);
    grant(0, 3'd0); offer(0, 32'h5);
    repeat (70001) tick();
    idle();
    tick();
    chk("cnt_sat_o0", 64'(flit_cnt_o[15:0]), 64'hFFFF);
    chk("cnt_others", 64'(flit_cnt_o[P*16-1:16]), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xbar_pipelined.md
Name: xbar_pipelined

Overview:
- Parametrised successor to the router's combinational crossbar: N×N switch for flat flit vectors with per-output valid/ready handshake and a registered output stage.
- Each output has a 2-entry skid buffer, so the switch absorbs downstream backpressure without combinational ready paths to the link.
- Sits between the input buffers and the output links; driven by the switch allocator's per-output input selection.

Parameters:
- PORT_NUM, 5, number of input ports and number of output ports.
- FLIT_W, 32, flit width in bits.
- SEL_W, $clog2(PORT_NUM), width of each per-output input-select field.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- data_i  input  PORT_NUM*FLIT_W  input flits; input i occupies bits [i*FLIT_W +: FLIT_W].
- valid_i  input  PORT_NUM  input i holds a flit.
- ready_o  output  PORT_NUM  input i's flit is consumed this cycle when valid_i[i] is also high.
- sel_i  input  PORT_NUM*SEL_W  for output o, the index of its source input, at [o*SEL_W +: SEL_W].
- sel_valid_i  input  PORT_NUM  output o has a grant this cycle.
- data_o  output  PORT_NUM*FLIT_W  output flits.
- valid_o  output  PORT_NUM  output o holds a flit.
- ready_i  input  PORT_NUM  downstream accepts output o.
- conflict_o  output  1  registered pulse: during the previous cycle, at least two granted outputs selected the same input.
- sel_err_o  output  1  registered pulse: during the previous cycle, a granted sel field was >= PORT_NUM.

Behaviour:
- Reset (async assert, sync deassert handled externally): all valid_o=0, data_o=0, skid entries empty, conflict_o=0, sel_err_o=0, counters=0.
- Per output o, state is a main register (drives data_o/valid_o) and a skid register. can_acc[o] = !skid_valid[o]. can_acc depends on state only.
- Grant resolution, combinational:
  - eff[o] = sel_valid_i[o] && sel_i[o] < PORT_NUM.
  - If several eff outputs select the same input, the lowest-indexed output wins and the others are masked this cycle.
- Transfer: xfer[o] = eff[o] && winner && valid_i[sel_i[o]] && can_acc[o].
- ready_o[i] = OR over o of (eff[o] && winner && sel_i[o]==i && can_acc[o]).
  - ready_o may be high while valid_i is low. The input is consumed only when both are high.
- Latency: a flit accepted in cycle t appears on data_o in cycle t+1 if the main register is free or draining.
- Output register update for output o, per cycle:
  - Main empty, or main valid with ready_i: main loads the skid if the skid is valid, otherwise the incoming xfer flit (else becomes invalid). If the skid was loaded into main and xfer is high, the incoming flit goes to the skid.
  - Main valid and !ready_i: main holds. An xfer flit goes to the skid. An xfer here is only possible when the skid is empty.
- FIFO order is preserved per output. No flit is dropped or duplicated. data_o and valid_o are stable while valid_o && !ready_i.
- Throughput: 1 flit/cycle/output under continuous ready_i.
- Full: skid valid forces can_acc=0, so ready_o is low for all inputs selected by o until the main register drains.
- conflict_o and sel_err_o are registered the cycle after the event and are single-cycle unless the event repeats.
- Reset mid-transfer: all buffered flits are discarded and outputs go invalid immediately.

Optional Feature:
- Macro XBAR_FLIT_CNT_EN.
- Defined:
  - Adds output port flit_cnt_o, PORT_NUM*16 bits.
  - One 16-bit counter per output, incremented on each valid_o && ready_i handshake. Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: the port and the counters are absent. Behaviour is otherwise identical.

Test Plan:
- Single flit: PORT_NUM=5, sel_i[2]=3, sel_valid_i[2]=1, valid_i[3]=1, data 32'hA5A5_0001, ready_i=all 1 -> ready_o[3]=1 in cycle t; data_o[2]=32'hA5A5_0001 and valid_o[2]=1 in t+1.
- Backpressure: stream 4 flits 1..4 into output 0 with ready_i[0]=0 for 3 cycles -> after 2 accepted, ready_o drops; after ready_i rises, output order is 1,2,3,4 with no loss.
- Conflict: outputs 1 and 4 both select input 0 -> only output 1 receives the flit; ready_o[0] is set by output 1; conflict_o=1 exactly one cycle later.
- Bad select: sel_i[0]=7, sel_valid_i[0]=1 -> no transfer, ready_o=0, sel_err_o pulses one cycle later.
- Reset mid-operation: assert rst_n=0 with both entries of output 2 full -> valid_o goes to all 0 asynchronously; after release, the first new flit passes with latency 1.
- XBAR_FLIT_CNT_EN: 70000 handshakes on output 0 -> flit_cnt_o[0]=16'hFFFF; other counters=0.
